// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Command-level controller in front of a WIDTH-bit ALU (negate, add,
//   subtract, AND, OR). Takes one command at a time and returns one result.
//   Single-pass ops take one EXEC cycle. MUL is an unsigned shift-and-add
//   loop over the adder with one iteration per multiplier bit (WIDTH cycles).
//
// Handshakes (valid/ready):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds valid and its payload stable until that edge. ready
//   may be driven independently of valid.
//   - cmd_*: cmd_ready is 1 only in IDLE while reset is low. cmd_valid is
//     ignored in every other state.
//   - res_*: res_valid is 1 only in DONE. res_data and the flags hold stable
//     until the transfer. res_ready is ignored outside DONE.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   cmd_valid  command present
//   cmd_ready  sequencer can accept a command
//   cmd_op     opcode: 000 NEG_A, 001 NEG_B, 010 SUB, 011 ADD, 100 AND,
//              101 OR, 110 MUL (unsigned), 111 illegal
//   cmd_a      operand A (WIDTH bits)
//   cmd_b      operand B (WIDTH bits)
//   res_valid  result present
//   res_ready  consumer takes the result
//   res_data   result (2*WIDTH bits; ALU results are zero-extended)
//   res_carry  adder carry-out for ADD/SUB (SUB: 1 = no borrow), else 0
//   res_zero   res_data == 0
//   res_err    illegal opcode
//   dbgState   current FSM state (IDLE=0, EXEC=1, MUL=2, DONE=3)
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_carry,
  output logic                 res_zero,
  output logic                 res_err,
  output logic [1:0]           dbgState
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_NEG_A = 3'b000;
  localparam logic [2:0] OP_NEG_B = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } stateE;

  stateE              state;
  logic [2:0]         opReg;
  logic [WIDTH-1:0]   aReg;
  logic [WIDTH-1:0]   bReg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      iter;

  // Single-pass ALU on the captured operands. The adder is one bit wider
  // than the operands so its top bit is the carry-out.
  logic [WIDTH:0]   aluSum;
  logic [WIDTH-1:0] aluRes;
  logic             aluCarry;
  logic             aluErr;

  always_comb begin
    aluSum   = '0;
    aluRes   = '0;
    aluCarry = 1'b0;
    aluErr   = 1'b0;
    case (opReg)
      OP_NEG_A: begin
        aluSum = {1'b0, ~aReg} + ONE;
        aluRes = aluSum[WIDTH-1:0];
      end
      OP_NEG_B: begin
        aluSum = {1'b0, ~bReg} + ONE;
        aluRes = aluSum[WIDTH-1:0];
      end
      OP_SUB: begin
        // Two's-complement subtract: carry-out 1 means no borrow.
        aluSum   = {1'b0, aReg} + {1'b0, ~bReg} + ONE;
        aluRes   = aluSum[WIDTH-1:0];
        aluCarry = aluSum[WIDTH];
      end
      OP_ADD: begin
        aluSum   = {1'b0, aReg} + {1'b0, bReg};
        aluRes   = aluSum[WIDTH-1:0];
        aluCarry = aluSum[WIDTH];
      end
      OP_AND: aluRes = aReg & bReg;
      OP_OR:  aluRes = aReg | bReg;
      default: aluErr = 1'b1;  // 111 (MUL never reaches EXEC)
    endcase
  end

  // One shift-and-add step: add A shifted by the iteration index when the
  // matching multiplier bit is set.
  logic [2*WIDTH-1:0] mulAddend;
  logic [2*WIDTH-1:0] mulNext;

  always_comb begin
    mulAddend = '0;
    if (bReg[iter]) begin
      mulAddend = {{WIDTH{1'b0}}, aReg} << iter;
    end
    mulNext = acc + mulAddend;
  end

  assign cmd_ready = (state == IDLE) && !reset;
  assign dbgState  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      opReg     <= '0;
      aReg      <= '0;
      bReg      <= '0;
      acc       <= '0;
      iter      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            opReg <= cmd_op;
            aReg  <= cmd_a;
            bReg  <= cmd_b;
            acc   <= '0;
            iter  <= '0;
            state <= (cmd_op == OP_MUL) ? MUL : EXEC;
          end
        end

        EXEC: begin
          res_data  <= {{WIDTH{1'b0}}, aluRes};
          res_carry <= aluCarry;
          res_err   <= aluErr;
          res_zero  <= (aluRes == '0);
          res_valid <= 1'b1;
          state     <= DONE;
        end

        MUL: begin
          acc <= mulNext;
          // Finish on the last bit instead of letting the counter wrap,
          // so exactly WIDTH iterations run regardless of operand values.
          if (iter == LAST_ITER) begin
            res_data  <= mulNext;
            res_carry <= 1'b0;
            res_err   <= 1'b0;
            res_zero  <= (mulNext == '0);
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            iter <= iter + CW'(1);
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
